// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcode, DSP control constants and tag type shared by the DSP scheduler.
package alu_sched_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_ADD  = 4'd3,
        OP_ADDC = 4'd4,
        OP_SUB  = 4'd5,
        OP_SEQ  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLTS = 4'd8
    } op_e;

    localparam logic [8:0] OPMODE_XZ     = 9'b000110011;
    localparam logic [8:0] OPMODE_OR     = 9'b000111011;
    localparam logic [3:0] ALUMODE_LOGIC = 4'b1100;
    localparam logic [3:0] ALUMODE_XOR   = 4'b0100;
    localparam logic [3:0] ALUMODE_ADD   = 4'b0000;
    localparam logic [3:0] ALUMODE_SUB   = 4'b0011;
    localparam logic [1:0] SETINST_NONE  = 2'b00;
    localparam logic [1:0] SETINST_EQ    = 2'b01;
    localparam logic [1:0] SETINST_LTU   = 2'b10;
    localparam logic [1:0] SETINST_LTS   = 2'b11;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [2:0] idx;
    } tag_t;

    typedef struct packed {
        logic [8:0] opmode;
        logic [3:0] alumode;
        logic [1:0] setinst;
        logic       legal;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [3:0] op);
        ctrl_t c;
        c = '{opmode: OPMODE_XZ, alumode: ALUMODE_SUB, setinst: SETINST_NONE, legal: 1'b1};
        case (op)
            OP_AND:          c.alumode = ALUMODE_LOGIC;
            OP_OR:           begin c.opmode = OPMODE_OR; c.alumode = ALUMODE_LOGIC; end
            OP_XOR:          c.alumode = ALUMODE_XOR;
            OP_ADD, OP_ADDC: c.alumode = ALUMODE_ADD;
            OP_SUB:          c.setinst = SETINST_NONE;
            OP_SEQ:          c.setinst = SETINST_EQ;
            OP_SLTU:         c.setinst = SETINST_LTU;
            OP_SLTS:         c.setinst = SETINST_LTS;
            default:         c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/AluDsp48.sv
// AluDsp48: behavioural DSP48-style ALU with a fixed in-to-out pipeline and no reset.
module AluDsp48 #(
    parameter int W       = 16,
    parameter int LATENCY = 2
) (
    input  logic         clock,
    input  logic [8:0]   opmode,
    input  logic [3:0]   alumode,
    input  logic [1:0]   setinst,
    input  logic         carryin,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         valid_in,
    output logic [W-1:0] out,
    output logic         carryout,
    output logic         valid_out
);

    logic [W:0]   sum, dif;
    logic [W-1:0] res;
    logic         cy, flag;
    logic [W+1:0] pipe [LATENCY];

    always_comb begin
        sum  = {1'b0, in0} + {1'b0, in1} + {{W{1'b0}}, carryin};
        dif  = {1'b0, in0} + {1'b0, ~in1} + (W+1)'(1);
        flag = setinst == 2'b01 ? in0 == in1 :
               setinst == 2'b10 ? in0 < in1 : $signed(in0) < $signed(in1);
        res  = alumode == 4'b1100 ? (opmode == 9'b000111011 ? in0 | in1 : in0 & in1) :
               alumode == 4'b0100 ? in0 ^ in1 :
               alumode == 4'b0000 ? sum[W-1:0] :
               setinst == 2'b00   ? dif[W-1:0] : {{(W-1){1'b0}}, flag};
        // Subtract reports carry as "no borrow", matching the DSP's native convention.
        cy   = alumode == 4'b0000 ? sum[W] : alumode == 4'b0011 ? dif[W] : 1'b0;
    end

    always_ff @(posedge clock) begin
        pipe[0] <= {valid_in, cy, res};
        for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
    end

    assign {valid_out, carryout, out} = pipe[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the pointer holds the last granted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N-1:0]         valid,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    logic [$clog2(N)-1:0] ptr;

    // Walk from the farthest candidate back to ptr+1 so the nearest valid one wins.
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        grant_idx = '0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (reset_n && valid[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                grant_idx = ($clog2(N))'(j);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) ptr <= ($clog2(N))'(N - 1);
        else if (|grant) ptr <= grant_idx;
    end

endmodule

// File: rtl/alu_dsp_scheduler.sv
// alu_dsp_scheduler: shares one AluDsp48 among N_REQ requesters with a tagged response bus.
module alu_dsp_scheduler import alu_sched_pkg::*; #(
    parameter int N_REQ   = 4,
    parameter int W       = 16,
    parameter int LATENCY = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0][3:0]     req_op,
    input  logic [N_REQ-1:0][W-1:0]   req_in0,
    input  logic [N_REQ-1:0][W-1:0]   req_in1,
    input  logic [N_REQ-1:0]          req_carryin,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [W-1:0]              rsp_out,
    output logic                      rsp_carryout,
    output logic                      rsp_err,
    output logic                      error_mismatch
);

    localparam int         IW   = $clog2(N_REQ);
    localparam logic [3:0] MASK = 4'(LATENCY + 2);

    logic [IW-1:0]      gidx;
    logic               fire, ok, hit, good;
    ctrl_t              ctl;
    tag_t               new_tag, tail;
    tag_t [LATENCY:0]   tags;
    logic [3:0]         mask_cnt;
    logic               iss_valid, iss_cin;
    logic [W-1:0]       iss_in0, iss_in1;
    logic [8:0]         iss_opmode;
    logic [3:0]         iss_alumode;
    logic [1:0]         iss_setinst;
    logic [W-1:0]       dsp_out;
    logic               dsp_cy, dsp_valid;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .valid     (req_valid),
        .grant     (req_ready),
        .grant_idx (gidx)
    );

    always_comb begin
        fire    = |req_ready;
        ctl     = decode(req_op[gidx]);
        ok      = fire & ctl.legal;
        new_tag = '{valid: fire, err: fire & ~ctl.legal, idx: 3'(gidx)};
        tail    = tags[LATENCY];
        hit     = tail.valid & reset_n;
        good    = hit & ~tail.err;
    end

    // Illegal ops still occupy a tag slot but never reach the DSP.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            iss_valid      <= 1'b0;
            iss_cin        <= 1'b0;
            iss_in0        <= '0;
            iss_in1        <= '0;
            iss_opmode     <= '0;
            iss_alumode    <= '0;
            iss_setinst    <= '0;
            tags           <= '0;
            mask_cnt       <= MASK;
            error_mismatch <= 1'b0;
        end else begin
            iss_valid      <= ok;
            iss_cin        <= ok & (req_op[gidx] == OP_ADDC) & req_carryin[gidx];
            iss_in0        <= ok ? req_in0[gidx] : '0;
            iss_in1        <= ok ? req_in1[gidx] : '0;
            iss_opmode     <= ctl.opmode;
            iss_alumode    <= ctl.alumode;
            iss_setinst    <= ctl.setinst;
            tags           <= {tags[LATENCY-1:0], new_tag};
            mask_cnt       <= mask_cnt != '0 ? mask_cnt - 4'd1 : mask_cnt;
            error_mismatch <= error_mismatch |
                              (mask_cnt == '0 && (tail.valid & ~tail.err) != dsp_valid);
        end
    end

    AluDsp48 #(.W(W), .LATENCY(LATENCY)) u_dsp (
        .clock     (clock),
        .opmode    (iss_opmode),
        .alumode   (iss_alumode),
        .setinst   (iss_setinst),
        .carryin   (iss_cin),
        .in0       (iss_in0),
        .in1       (iss_in1),
        .valid_in  (iss_valid),
        .out       (dsp_out),
        .carryout  (dsp_cy),
        .valid_out (dsp_valid)
    );

    assign rsp_valid    = hit ? N_REQ'(1) << tail.idx : '0;
    assign rsp_err      = hit & tail.err;
    assign rsp_out      = good ? dsp_out : '0;
    assign rsp_carryout = good & dsp_cy;

endmodule

// File: tb/tb_alu_dsp_scheduler.sv
// tb_alu_dsp_scheduler: directed vector table plus fairness and reset-flush sequences.
module tb_alu_dsp_scheduler;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [3:0]        req_valid, req_ready, req_carryin, rsp_valid;
    logic [3:0][3:0]   req_op;
    logic [3:0][15:0]  req_in0, req_in1;
    logic [15:0]       rsp_out;
    logic              rsp_carryout, rsp_err, error_mismatch;
    int                nvec = 0;
    int                nerr = 0;

    typedef struct {
        int          r;
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] q;
        logic        cy;
        logic        cychk;
        logic        err;
    } vec_t;

    vec_t vt [14];

    alu_dsp_scheduler #(.N_REQ(4), .W(16), .LATENCY(2)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_in0        (req_in0),
        .req_in1        (req_in1),
        .req_carryin    (req_carryin),
        .rsp_valid      (rsp_valid),
        .rsp_out        (rsp_out),
        .rsp_carryout   (rsp_carryout),
        .rsp_err        (rsp_err),
        .error_mismatch (error_mismatch)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_op = '0;
        req_in0 = '0;
        req_in1 = '0;
        req_carryin = '0;
    endtask

    initial begin
        //          r  op     in0       in1      cin   result   cy  cychk err
        vt[0]  = '{0, 4'd3,  16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{1, 4'd4,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{1, 4'd3,  16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{2, 4'd8,  16'h8000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{3, 4'd7,  16'h8000, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{0, 4'd6,  16'h0005, 16'h0005, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1, 4'd5,  16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{2, 4'd0,  16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{3, 4'd1,  16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{0, 4'd2,  16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{2, 4'd12, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
        vt[11] = '{3, 4'd6,  16'h0005, 16'h0006, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[12] = '{0, 4'd8,  16'h0001, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1, 4'd4,  16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b1, 1'b0};

        clear_reqs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 req_valid = 4'hF;
        #1;
        check("reset_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_out", rsp_out, 0);
        check("reset_rsp_cy_err", {rsp_carryout, rsp_err}, 0);
        check("reset_mismatch", error_mismatch, 0);
        clear_reqs();
        @(posedge clock);
        #1 reset_n = 1'b1;

        foreach (vt[i]) begin
            @(posedge clock);
            #1;
            clear_reqs();
            req_valid[vt[i].r] = 1'b1;
            req_op[vt[i].r] = vt[i].op;
            req_in0[vt[i].r] = vt[i].a;
            req_in1[vt[i].r] = vt[i].b;
            req_carryin[vt[i].r] = vt[i].cin;
            #1 check($sformatf("v%0d_ready", i), req_ready, 32'(1) << vt[i].r);
            @(posedge clock);
            #1 clear_reqs();
            #1 check($sformatf("v%0d_early1", i), rsp_valid, 0);
            @(posedge clock);
            #2 check($sformatf("v%0d_early2", i), rsp_valid, 0);
            @(posedge clock);
            #2;
            check($sformatf("v%0d_rsp_valid", i), rsp_valid, 32'(1) << vt[i].r);
            check($sformatf("v%0d_rsp_out", i), rsp_out, vt[i].q);
            check($sformatf("v%0d_rsp_err", i), rsp_err, vt[i].err);
            if (vt[i].cychk) check($sformatf("v%0d_rsp_cy", i), rsp_carryout, vt[i].cy);
            check($sformatf("v%0d_mismatch", i), error_mismatch, 0);
        end

        // Fairness: all requesters valid for 8 cycles, starting from a fresh pointer.
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            req_op[r] = 4'd3;
            req_in0[r] = 16'(r);
            req_in1[r] = 16'h0100;
        end
        for (int c = 0; c < 12; c++) begin
            #1 req_valid = c < 8 ? 4'hF : 4'h0;
            #1;
            check($sformatf("fair_ready_c%0d", c), req_ready, c < 8 ? 32'(1) << (c % 4) : 0);
            if (c >= 3 && c < 11) begin
                check($sformatf("fair_rsp_valid_c%0d", c), rsp_valid, 32'(1) << ((c - 3) % 4));
                check($sformatf("fair_rsp_out_c%0d", c), rsp_out, 32'h100 + 32'((c - 3) % 4));
            end else begin
                check($sformatf("fair_rsp_idle_c%0d", c), rsp_valid, 0);
            end
            @(posedge clock);
        end

        // Reset mid-flight: three accepted ops must never report.
        #1 clear_reqs();
        req_valid[0] = 1'b1;
        req_op[0] = 4'd3;
        req_in0[0] = 16'h0011;
        req_in1[0] = 16'h0022;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_ready", req_ready, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        req_valid = 4'b1001;
        #1 check("midrst_first_grant", req_ready, 4'b0001);
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #2;
            check($sformatf("midrst_flush_c%0d", c), rsp_valid, 0);
            check($sformatf("midrst_mismatch_c%0d", c), error_mismatch, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_dsp_scheduler.md
# alu_dsp_scheduler

Shares one AluDsp48 instance between N_REQ requesters. Round-robin arbitration picks at most one request per cycle. The block decodes a compact 4-bit opcode into the DSP opmode/alumode/setinst controls and tracks each in-flight operation with a tag pipeline. It then returns each result on a shared response bus with a one-hot valid that names the requester. It sits between the core's issue logic and the DSP-based ALU.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 16, datapath width
- LATENCY, 2, AluDsp48 in-to-out latency in cycles
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot grant; handshake = valid & ready
- req_op  in  N_REQ×4  opcode per requester
- req_in0, req_in1  in  N_REQ×W  operands
- req_carryin  in  N_REQ  carry-in, used only by ADDC
- rsp_valid  out  N_REQ  one-hot, one cycle per completed request
- rsp_out  out  W  result
- rsp_carryout  out  1  DSP carry-out
- rsp_err  out  1  illegal-opcode response
- error_mismatch  out  1  sticky: DSP valid_out disagrees with the tag pipeline

## Operation
- Opcodes and their DSP controls, as opmode/alumode/setinst:
  - 0 AND: 000110011/1100/00
  - 1 OR: 000111011/1100/00
  - 2 XOR: 000110011/0100/00
  - 3 ADD: 000110011/0000/00, carryin forced 0
  - 4 ADDC: same as ADD, carryin = req_carryin
  - 5 SUB: 000110011/0011/00
  - 6 SEQ: 000110011/0011/01
  - 7 SLTU: 000110011/0011/10
  - 8 SLTS: 000110011/0011/11
  - 9–15: illegal.
- carryin is 0 for every opcode except ADDC.
- Arbiter:
  - Round-robin; the pointer holds the index of the last granted requester.
  - Search starts at pointer+1 and wraps at N_REQ-1→0.
  - The pointer updates only on a handshake.
  - req_ready is combinational from req_valid and the pointer; at most one bit is set.
  - No grants while reset_n=0.
- Issue stage: registers the granted operands, decoded controls and dsp valid_in.
  - Legal op: valid_in=1.
  - Illegal op: valid_in=0, operands 0. The request is still accepted and tagged err=1.
- Tag pipeline:
  - LATENCY+1 entries of {valid, err, idx}, one entry per cycle of request latency.
  - The tail entry drives rsp_valid[idx] = valid.
- Response bus:
  - rsp_err = err.
  - rsp_out and rsp_carryout come from the DSP when err=0; they are forced to 0 when err=1.
  - Response buses are 0 when no response is valid.
- Results per opcode:
  - SUB gives in0−in1 mod 2^W.
  - ADD/ADDC give (in0+in1+cin) mod 2^W.
  - SEQ/SLTU/SLTS give 0 or 1 in bit 0, upper bits 0.
- Responses have no backpressure; requesters must always accept. The same requester may have up to LATENCY+1 operations in flight; responses return in issue order.
- Consistency check: each cycle, compare the tail entry's (valid & ~err) with DSP valid_out. A mismatch sets error_mismatch, which clears only on reset.

## Timing
- A handshake at edge t gives rsp_valid one cycle high in cycle t+LATENCY+1 (cycle 3 with defaults). Throughput is one op per cycle.
- Reset values: req_ready=0, rsp_valid=0, rsp_out=0, rsp_carryout=0, rsp_err=0, error_mismatch=0. Pointer resets to N_REQ-1, so requester 0 wins first.
- Reset mid-operation flushes all tag and issue entries. In-flight results are dropped and never reported.
- AluDsp48 has no reset, so the consistency check is masked for LATENCY+2 cycles after reset_n rises.
- If all requesters are valid, each is granted exactly once every N_REQ cycles.
- When no request is valid, the issue stage drives valid_in=0 and holds the pointer.

## Structure
- Shared package alu_sched_pkg holds:
  - the opcode enum (op_e);
  - OPMODE_*/ALUMODE_*/SETINST_* constants;
  - the tag struct {valid, err, idx}.
- Sub-module rr_arbiter(N) holds the pointer and one-hot grant logic.
- AluDsp48 is instantiated unchanged; decode and tag pipeline live in the top.

## Test plan
- Single request: req0 ADD in0=0x0003, in1=0x0004 at t. Then rsp_valid=0001, rsp_out=0x0007 at t+3; nothing else pulses.
- ADDC wrap: in0=0xFFFF, in1=0x0000, cin=1. Then rsp_out=0x0000, rsp_carryout=1.
  - The same operands with ADD give 0xFFFF, because cin is forced 0.
- Compare ops:
  - SLTS 0x8000 vs 0x0001 → 1.
  - SLTU 0x8000 vs 0x0001 → 0.
  - SEQ 5 vs 5 → 1.
  - SUB 0x0001−0x0002 → 0xFFFF.
- Fairness: all 4 requesters held valid for 8 cycles. Grants are 0,1,2,3,0,1,2,3, and responses come back in that order 3 cycles later.
- Illegal opcode 12 from req2: rsp_valid=0100, rsp_err=1, rsp_out=0 at t+3; error_mismatch stays 0.
- Reset mid-flight: 3 ops accepted, then reset_n=0 for 1 cycle. No rsp_valid for those ops, error_mismatch=0, and req0 is granted first afterwards.
